// File: rtl/alu_ctrl_fsm.sv
// Calculator control FSM: turns debounced button levels into press events,
// sequences operand loads (A then B) and cycles the ALU operation with a post-press lockout.
module alu_ctrl_fsm #(
    parameter int HOLD_CYCLES = 16,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enter,
    input  logic       sign,
    input  logic       reload,
    output logic [1:0] reg_ctrl,
    output logic [3:0] alu_ctrl,
    output logic [2:0] state_o,
    output logic       busy
);

    typedef enum logic [2:0] {
        LOAD_A = 3'b000,
        LOAD_B = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_MOD = 3'b100
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_VAL = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    logic             enter_d_r;
    logic             sign_d_r;
    logic             reload_d_r;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       reg_ctrl_r;
    logic [3:0]       alu_ctrl_r;
    logic             busy_r;

    logic enter_press_s;
    logic sign_press_s;
    logic reload_press_s;
    logic idle_s;

    assign enter_press_s  = enter & ~enter_d_r;
    assign sign_press_s   = sign & ~sign_d_r;
    assign reload_press_s = reload & ~reload_d_r;
    assign idle_s         = (cnt_r == {CNT_W{1'b0}});

    // Registered state, strobe, ALU command, edge history and lockout counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= LOAD_A;
            enter_d_r  <= 1'b1;
            sign_d_r   <= 1'b1;
            reload_d_r <= 1'b1;
            cnt_r      <= {CNT_W{1'b0}};
            reg_ctrl_r <= 2'b00;
            alu_ctrl_r <= 4'b0000;
            busy_r     <= 1'b0;
        end else begin
            enter_d_r  <= enter;
            sign_d_r   <= sign;
            reload_d_r <= reload;
            reg_ctrl_r <= 2'b00;

            if (sign_press_s) begin
                alu_ctrl_r[3] <= ~alu_ctrl_r[3];
            end

            if (!idle_s) begin
                cnt_r  <= cnt_r - CNT_ONE;
                busy_r <= (cnt_r > CNT_ONE);
            end else begin
                busy_r <= 1'b0;
            end

            // Presses are only honoured with the counter already at zero; the
            // counter load below overrides the decrement on an accepted press.
            if (idle_s) begin
                case (state_r)
                    LOAD_A: begin
                        if (enter_press_s) begin
                            state_r         <= LOAD_B;
                            reg_ctrl_r      <= 2'b01;
                            alu_ctrl_r[2:0] <= 3'b000;
                            cnt_r           <= HOLD_VAL;
                            busy_r          <= 1'b1;
                        end
                    end
                    LOAD_B: begin
                        if (enter_press_s) begin
                            state_r         <= OP_ADD;
                            reg_ctrl_r      <= 2'b10;
                            alu_ctrl_r[2:0] <= 3'b000;
                            cnt_r           <= HOLD_VAL;
                            busy_r          <= 1'b1;
                        end
                    end
                    OP_ADD, OP_SUB, OP_MOD: begin
                        if (reload_press_s) begin
                            state_r         <= LOAD_A;
                            alu_ctrl_r[2:0] <= 3'b000;
                            cnt_r           <= HOLD_VAL;
                            busy_r          <= 1'b1;
                        end else if (enter_press_s) begin
                            cnt_r  <= HOLD_VAL;
                            busy_r <= 1'b1;
                            if (state_r == OP_ADD) begin
                                state_r         <= OP_SUB;
                                alu_ctrl_r[2:0] <= 3'b001;
                            end else if (state_r == OP_SUB) begin
                                state_r         <= OP_MOD;
                                alu_ctrl_r[2:0] <= 3'b010;
                            end else begin
                                state_r         <= OP_ADD;
                                alu_ctrl_r[2:0] <= 3'b000;
                            end
                        end
                    end
                    default: begin
                        state_r         <= LOAD_A;
                        alu_ctrl_r[2:0] <= 3'b000;
                    end
                endcase
            end
        end
    end

    assign reg_ctrl = reg_ctrl_r;
    assign alu_ctrl = alu_ctrl_r;
    assign state_o  = state_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Bench for alu_ctrl_fsm: directed scenarios with literal expectations, then
// random button activity, all compared every cycle against a behavioural model.
module tb_alu_ctrl_fsm;

    localparam int HOLD = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enter = 1'b0;
    logic       sign = 1'b0;
    logic       reload = 1'b0;
    logic [1:0] reg_ctrl;
    logic [3:0] alu_ctrl;
    logic [2:0] state_o;
    logic       busy;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit chk_en = 1'b0;

    // model: phase 0 = load A, 1 = load B, 2..4 = add/sub/mod
    int m_phase = 0;
    int m_cnt = 0;
    int m_strobe = 0;
    bit m_sign = 1'b0;
    bit pe = 1'b1, ps = 1'b1, pr = 1'b1;

    alu_ctrl_fsm #(.HOLD_CYCLES(HOLD), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .enter(enter), .sign(sign), .reload(reload),
        .reg_ctrl(reg_ctrl), .alu_ctrl(alu_ctrl), .state_o(state_o), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // behavioural reference, advanced on each rising edge
    always @(posedge clk) begin
        bit ep, sp, rp, acc;
        if (!rst_n) begin
            m_phase = 0; m_cnt = 0; m_strobe = 0; m_sign = 1'b0;
            pe = 1'b1; ps = 1'b1; pr = 1'b1;
        end else begin
            ep = enter && !pe; sp = sign && !ps; rp = reload && !pr;
            pe = enter; ps = sign; pr = reload;
            m_strobe = 0;
            acc = 1'b0;
            if (sp) m_sign = !m_sign;
            if (m_cnt == 0) begin
                if (m_phase >= 2 && rp) begin
                    m_phase = 0; acc = 1'b1;
                end else if (ep) begin
                    acc = 1'b1;
                    if (m_phase < 2) begin
                        m_strobe = m_phase + 1;
                        m_phase = m_phase + 1;
                    end else begin
                        m_phase = 2 + ((m_phase - 1) % 3);
                    end
                end
            end
            if (acc) m_cnt = HOLD;
            else if (m_cnt > 0) m_cnt = m_cnt - 1;
        end
    end

    // compare DUT outputs with the model mid-cycle
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_state", {5'd0, state_o}, 8'(m_phase));
            chk("model_reg_ctrl", {6'd0, reg_ctrl}, 8'(m_strobe));
            chk("model_alu_ctrl", {4'd0, alu_ctrl},
                {4'd0, m_sign, (m_phase >= 2) ? 3'(m_phase - 2) : 3'd0});
            chk("model_busy", {7'd0, busy}, {7'd0, m_cnt != 0});
        end
    end

    task automatic step(input logic e, input logic s, input logic r, input logic rn);
        @(negedge clk);
        enter = e; sign = s; reload = r; rst_n = rn;
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // drive a one-cycle pulse, sample after the edge that sees it
    task automatic press(input logic e, input logic s, input logic r);
        step(e, s, r, 1'b1);
        edge_wait();
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        edge_wait();
        chk("rst_state", {5'd0, state_o}, 8'h00);
        chk("rst_reg_ctrl", {6'd0, reg_ctrl}, 8'h00);
        chk("rst_alu_ctrl", {4'd0, alu_ctrl}, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'h00);
        idle(5);

        // enter held for 5 cycles: one strobe, lockout of HOLD cycles
        step(1'b1, 1'b0, 1'b0, 1'b1);
        edge_wait();
        chk("loada_strobe", {6'd0, reg_ctrl}, 8'h01);
        chk("loada_state", {5'd0, state_o}, 8'h01);
        chk("loada_busy", {7'd0, busy}, 8'h01);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        edge_wait();
        chk("strobe_one_cycle", {6'd0, reg_ctrl}, 8'h00);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(20);
        press(1'b1, 1'b0, 1'b0);
        chk("loadb_strobe", {6'd0, reg_ctrl}, 8'h02);
        chk("loadb_state", {5'd0, state_o}, 8'h02);
        chk("loadb_alu", {4'd0, alu_ctrl}, 8'h00);
        idle(20);

        // operation cycling
        press(1'b1, 1'b0, 1'b0);
        chk("op_sub_alu", {4'd0, alu_ctrl}, 8'h01);
        chk("op_sub_state", {5'd0, state_o}, 8'h03);
        idle(20);
        press(1'b1, 1'b0, 1'b0);
        chk("op_mod_alu", {4'd0, alu_ctrl}, 8'h02);
        chk("op_mod_state", {5'd0, state_o}, 8'h04);
        idle(20);
        press(1'b1, 1'b0, 1'b0);
        chk("op_wrap_alu", {4'd0, alu_ctrl}, 8'h00);
        chk("op_wrap_state", {5'd0, state_o}, 8'h02);
        idle(20);
        press(1'b1, 1'b0, 1'b0);
        chk("op_sub2_state", {5'd0, state_o}, 8'h03);
        chk("op_reg_ctrl_quiet", {6'd0, reg_ctrl}, 8'h00);

        // re-press 5 cycles later is dropped by the lockout
        idle(3);
        press(1'b1, 1'b0, 1'b0);
        chk("lockout_drop", {5'd0, state_o}, 8'h03);
        idle(20);
        press(1'b1, 1'b0, 1'b1);
        chk("reload_wins_state", {5'd0, state_o}, 8'h00);
        chk("reload_wins_alu", {4'd0, alu_ctrl}, 8'h00);
        idle(20);

        // sign toggles, including together with an accepted enter
        press(1'b0, 1'b1, 1'b0);
        chk("sign1", {4'd0, alu_ctrl}, 8'h08);
        idle(2);
        press(1'b1, 1'b1, 1'b0);
        chk("sign2", {4'd0, alu_ctrl}, 8'h00);
        chk("sign2_state", {5'd0, state_o}, 8'h01);
        idle(20);
        press(1'b0, 1'b1, 1'b0);
        chk("sign3", {4'd0, alu_ctrl}, 8'h08);
        press(1'b1, 1'b0, 1'b0);
        idle(20);
        press(1'b0, 1'b0, 1'b1);
        chk("sign_after_reload", {4'd0, alu_ctrl}, 8'h08);
        chk("reload_state", {5'd0, state_o}, 8'h00);
        idle(20);

        // enter held through reset release
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1);
        edge_wait();
        chk("held_enter_state", {5'd0, state_o}, 8'h00);
        chk("held_enter_reg", {6'd0, reg_ctrl}, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        chk("repress_state", {5'd0, state_o}, 8'h01);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        edge_wait();
        chk("rst_busy_clear", {7'd0, busy}, 8'h00);
        chk("rst_busy_state", {5'd0, state_o}, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // random button activity
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 7) == 0) ? ~enter : enter,
                 ($urandom_range(0, 9) == 0) ? ~sign : sign,
                 ($urandom_range(0, 23) == 0) ? ~reload : reload,
                 ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1);
        end
        idle(2);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_fsm.md
Name: alu_ctrl_fsm

Overview:
Control state machine directly upstream of the operand register stage in the Lab3 calculator datapath. Converts debounced push-button levels (enter, sign, reload) into single-cycle press events. Sequences operand loading (A, then B) and the ALU operation cycle (add, sub, mod3). Drives the register-load strobe (reg_ctrl) consumed by the operand register stage and the ALU command word (alu_ctrl).

Parameters:
HOLD_CYCLES, 16, lockout length in clocks after an accepted enter/reload press; range 1..65535.
CNT_W, 16, width of the lockout counter; must hold HOLD_CYCLES.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
enter  input  1  debounced enter button level, active high
sign  input  1  debounced sign-mode button level, active high
reload  input  1  debounced reload button level, active high
reg_ctrl  output  2  load strobe: 2'b01 load A, 2'b10 load B, 2'b00 hold
alu_ctrl  output  4  [2:0] op (000 add, 001 sub, 010 mod3), [3] signed mode
state_o  output  3  current state code, for LEDs
busy  output  1  high while lockout counter is nonzero

Behaviour:
- Single clock domain. Reset is synchronous and active-low: clk and rst_n; rst_n sampled low at a rising edge resets all state on that edge.
- Reset values: state LOAD_A, reg_ctrl 2'b00, alu_ctrl 4'b0000, state_o 3'b000, busy 0, lockout counter 0.
- Reset also sets the edge-detect history registers (enter_d, sign_d, reload_d) to 1, so a button held through reset release gives no press until released and pressed again.
- Edge detect: press = level & ~level_d, evaluated at each rising edge; level_d <= level every cycle.
- All outputs are registered. Outputs change on the same edge where the press is detected, i.e. 1 clock after the level is first sampled high.
- States and encodings: LOAD_A 000, LOAD_B 001, OP_ADD 010, OP_SUB 011, OP_MOD 100.
- Transitions on an accepted enter press:
  - LOAD_A -> LOAD_B, reg_ctrl=01 for exactly 1 cycle.
  - LOAD_B -> OP_ADD, reg_ctrl=10 for exactly 1 cycle.
  - OP_ADD -> OP_SUB -> OP_MOD -> OP_ADD (wraps); reg_ctrl stays 00.
- Accepted reload press in OP_ADD, OP_SUB or OP_MOD -> LOAD_A, reg_ctrl 00. Reload is ignored in LOAD_A and LOAD_B.
- reg_ctrl is 00 in every cycle except the single strobe cycle. It is never 11.
- alu_ctrl[2:0]:
  - OP_ADD 000, OP_SUB 001, OP_MOD 010.
  - 000 in LOAD_A and LOAD_B.
  - Registered, so it tracks state_o with no skew.
- alu_ctrl[3] toggles on each sign press, in any state, with no lockout. It is preserved across reload and cleared only by reset.
- Lockout:
  - Any accepted enter or reload press loads the counter with HOLD_CYCLES; the counter then decrements by 1 per clock to 0. busy = (counter != 0).
  - Enter/reload presses detected while busy=1 are dropped, not queued.
  - A press on the edge where the counter reaches 0 is also dropped. Acceptance requires counter == 0 at that edge.
- Simultaneous enter and reload presses: in op states reload wins and enter is discarded; in load states enter wins. The counter is loaded once.
- Simultaneous sign and enter/reload: both take effect on the same edge.
- Reset mid-lockout or mid-strobe: everything returns to reset values on that edge, and no strobe is emitted after reset.

Test Plan:
- Reset with all buttons low, then release -> state_o=000, reg_ctrl=00, alu_ctrl=0000, busy=0.
- enter rises at cycle 10, held 5 cycles -> reg_ctrl=01 in cycle 11 only, state_o=001, busy high for 16 cycles. Second press after busy clears -> reg_ctrl=10 one cycle, state_o=010, alu_ctrl=0000.
- From OP_ADD, four spaced enter presses -> alu_ctrl[2:0] = 001, 010, 000, 001; state_o = 011, 100, 010, 011; reg_ctrl stays 00.
- Enter re-pressed 5 cycles after an accepted press (HOLD_CYCLES=16) -> ignored, state unchanged; enter and reload pressed together in OP_SUB -> state_o=000, alu_ctrl[2:0]=000.
- sign pressed 3 times, including once on the same edge as an accepted enter press -> alu_ctrl[3] sequence 1, 0, 1, state also advances; bit persists through reload.
- enter held high across rst_n deassertion -> no transition until enter goes low and high again. rst_n asserted during busy -> counter 0, busy 0 on that edge.
